test_packet_gen: RTL and testbench
==================================

# test_packet_gen

Byte-stream test-traffic generator: the transmit end paired with `detect_errors`. It emits back-to-back fixed-size packets on a `tx_en`/`tx_data` byte interface at 125 MHz. Each packet carries a round (aux) byte and a 16-bit segment number, so the receiver can classify packets as ok, ng or lost. A drop-request input suppresses chosen packet slots, so loss accounting can be exercised on hardware and in simulation.

## Interface
- `PACKETSIZE`, 33: bytes per packet; must be ≥ 3.
- `WHEREIS_AUX`, 0: byte index carrying the aux (round) byte.
- `SEG_POS`, 1: byte index of segment number MSB; LSB at `SEG_POS+1`; must not overlap `WHEREIS_AUX`.
- `IFG`, 10: idle cycles between packets; must be ≥ 1.
- `FILL`, 8'h12: value of every other payload byte.

Ports:
- `clk` in 1: system clock, 125 MHz.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; generate while high.
- `segment_number_max` in 16: packets per round; 0 is treated as 1.
- `drop_req` in 1: level; sampled at slot start; high means the slot is silent.
- `tx_en` out 1: byte valid.
- `tx_data` out 8: packet byte; 8'h00 when `tx_en` is low.
- `aux` out 8: current round number.
- `seg_num` out 16: segment number of the current or next slot.
- `sent_count` out 32: packets actually transmitted.
- `dropped_count` out 32: slots suppressed.
- `busy` out 1: high when the state is not IDLE.
- `state` out 2: FSM state, for debug.

## Operation
- FSM states:
  - IDLE = 0
  - SEND = 1 (packet or silent slot)
  - GAP = 2
- IDLE → SEND when `enable` = 1.
  - At this transition, latch `drop_req` into `drop_slot` and clear the byte counter `idx`.
- SEND, each cycle:
  - `idx` increments.
  - When `idx` = PACKETSIZE-1, go to GAP and clear the gap counter.
- GAP: count IFG cycles. On the last gap cycle:
  - If `enable` = 1, go to SEND, latching `drop_req` and clearing `idx`.
  - Otherwise go to IDLE.
- Dropping `enable` mid-packet never truncates the packet; the slot and its gap always complete.
- Byte content during SEND with `drop_slot` = 0:
  - `idx` = WHEREIS_AUX: `aux`.
  - `idx` = SEG_POS: `seg_num[15:8]`.
  - `idx` = SEG_POS+1: `seg_num[7:0]`.
  - Any other index: FILL.
- With `drop_slot` = 1, `tx_en` stays 0 for the whole slot, but slot timing is unchanged.
- Counter update on the last SEND cycle (i.e. on every slot, transmitted or dropped):
  - `sent_count` += 1 if not dropped; otherwise `dropped_count` += 1.
  - If `seg_num` ≥ max(`segment_number_max`,1) − 1: `seg_num` ← 0 and `aux` ← `aux` + 1, wrapping at 8 bits.
  - Otherwise `seg_num` += 1.
- The ≥ comparison means that lowering `segment_number_max` mid-round wraps at the next slot end.
- `sent_count` and `dropped_count` wrap modulo 2^32.
- `segment_number_max` is sampled only at slot end.

## Timing
- Reset values: state IDLE, `tx_en` 0, `tx_data` 0, `aux` 0, `seg_num` 0, both counts 0, `busy` 0.
- `tx_en` and `tx_data` are registered.
- If `enable` is sampled high in IDLE at edge n, byte 0 appears after edge n+1.
- A packet occupies exactly PACKETSIZE consecutive cycles; slot period is PACKETSIZE+IFG cycles (43 at defaults).
- `aux` and `seg_num` change on the edge after the last byte. They are therefore stable for the whole packet that carries them.
- `rst` mid-packet: `tx_en` is 0 after that edge, all state returns to reset values, and there is no partial-packet completion.
- `rst` has priority over `enable`.
- `drop_req` is sampled only at slot start; it is ignored mid-slot.

## Structure
- Shared package `test_packet_pkg`:
  - state encoding constants (IDLE/SEND/GAP);
  - default PACKETSIZE, WHEREIS_AUX, SEG_POS and FILL values, shared with `detect_errors` so both ends agree on the layout.
- Optional sub-module `packet_byte_mux` (combinational): maps `idx`/`aux`/`seg_num` to a byte. Everything else is in one module.

## Test plan
- Reset then `enable`=1, `segment_number_max`=3, defaults:
  - first packet bytes = 00,00,00, then 30×12;
  - next packets carry seg 1 and seg 2;
  - the fourth packet has `aux`=1, seg 0;
  - packet starts are exactly 43 cycles apart.
- `drop_req` high for slots 2–3 of 5, max=50:
  - `tx_en` is silent for those 66 cycles;
  - `sent_count`=3, `dropped_count`=2;
  - the fifth packet carries seg 4.
- `enable` dropped at byte 10 of a packet:
  - the packet completes all 33 bytes, then 10 gap cycles, then IDLE;
  - `busy` falls after the gap.
- `segment_number_max`=0: every packet has seg 0 and `aux` increments each packet, 00→01→02.
- `rst` pulsed at byte 15: `tx_en`=0 on the next cycle; counts, `aux` and `seg_num` = 0; with `enable` high, the next packet starts fresh with seg 0.
- 256 rounds with max=1: `aux` wraps FF→00 and `sent_count`=256. Loopback into `detect_errors` shows ok=256, ng=0 and lost=0.

Source files
------------

// File: rtl/test_packet_pkg.sv
// Layout and state encoding shared by test_packet_gen and detect_errors,
// so both ends of the link agree on where the aux and segment bytes sit.
package test_packet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int         PACKETSIZE_DEF  = 33;
  localparam int         WHEREIS_AUX_DEF = 0;
  localparam int         SEG_POS_DEF     = 1;
  localparam int         IFG_DEF         = 10;
  localparam logic [7:0] FILL_DEF        = 8'h12;

endpackage

// File: rtl/packet_byte_mux.sv
// Combinational byte selector: maps a byte index within a packet to the aux
// byte, one of the two segment-number bytes, or the fill pattern.
module packet_byte_mux
  import test_packet_pkg::*;
#(
  parameter int         WHEREIS_AUX = WHEREIS_AUX_DEF,
  parameter int         SEG_POS     = SEG_POS_DEF,
  parameter logic [7:0] FILL        = FILL_DEF
) (
  input  logic [15:0] idx,
  input  logic [7:0]  aux,
  input  logic [15:0] seg_num,
  output logic [7:0]  data
);

  localparam logic [15:0] AUX_IDX    = 16'(WHEREIS_AUX);
  localparam logic [15:0] SEG_HI_IDX = 16'(SEG_POS);
  localparam logic [15:0] SEG_LO_IDX = 16'(SEG_POS + 1);

  always_comb begin
    data = FILL;
    if (idx == AUX_IDX)         data = aux;
    else if (idx == SEG_HI_IDX) data = seg_num[15:8];
    else if (idx == SEG_LO_IDX) data = seg_num[7:0];
  end

endmodule

// File: rtl/test_packet_gen.sv
// Test-traffic generator: back-to-back fixed-size packets tagged with a round
// byte and segment number; drop_req turns a whole slot silent at slot start.
module test_packet_gen
  import test_packet_pkg::*;
#(
  parameter int         PACKETSIZE  = PACKETSIZE_DEF,
  parameter int         WHEREIS_AUX = WHEREIS_AUX_DEF,
  parameter int         SEG_POS     = SEG_POS_DEF,
  parameter int         IFG         = IFG_DEF,
  parameter logic [7:0] FILL        = FILL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] segment_number_max,
  input  logic        drop_req,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [7:0]  aux,
  output logic [15:0] seg_num,
  output logic [31:0] sent_count,
  output logic [31:0] dropped_count,
  output logic        busy,
  output logic [1:0]  state
);

  localparam logic [15:0] LAST_IDX = 16'(PACKETSIZE - 1);
  localparam logic [15:0] LAST_GAP = 16'(IFG - 1);

  state_t      state_q, state_d;
  logic [15:0] idx;
  logic [15:0] gap_cnt;
  logic        drop_slot;
  logic        slot_start;
  logic        last_byte;
  logic [15:0] seg_last;
  logic [7:0]  mux_byte;

  packet_byte_mux #(
    .WHEREIS_AUX (WHEREIS_AUX),
    .SEG_POS     (SEG_POS),
    .FILL        (FILL)
  ) u_byte_mux (
    .idx     (idx),
    .aux     (aux),
    .seg_num (seg_num),
    .data    (mux_byte)
  );

  // Valid/ready does not apply: tx_en is a pure valid qualifier with no
  // back-pressure; tx_data is forced to zero whenever tx_en is low.

  always_comb begin
    state_d    = state_q;
    slot_start = 1'b0;
    last_byte  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = SEND;
          slot_start = 1'b1;
        end
      end
      SEND: begin
        if (idx == LAST_IDX) begin
          state_d   = GAP;
          last_byte = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == LAST_GAP) begin
          if (enable) begin
            state_d    = SEND;
            slot_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A max of 0 behaves as 1, so the last segment of a round is max-1 floored at 0.
  assign seg_last = (segment_number_max == 16'd0) ? 16'd0 : segment_number_max - 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      gap_cnt       <= '0;
      drop_slot     <= 1'b0;
      tx_en         <= 1'b0;
      tx_data       <= 8'h00;
      aux           <= 8'h00;
      seg_num       <= 16'h0000;
      sent_count    <= '0;
      dropped_count <= '0;
    end else begin
      if (slot_start) begin
        drop_slot <= drop_req;
        idx       <= '0;
      end else if (state_q == SEND) begin
        idx <= idx + 16'd1;
      end

      if (last_byte)            gap_cnt <= '0;
      else if (state_q == GAP)  gap_cnt <= gap_cnt + 16'd1;

      tx_en   <= (state_q == SEND) && !drop_slot;
      tx_data <= ((state_q == SEND) && !drop_slot) ? mux_byte : 8'h00;

      if (last_byte) begin
        if (drop_slot) dropped_count <= dropped_count + 32'd1;
        else           sent_count    <= sent_count + 32'd1;
        if (seg_num >= seg_last) begin
          seg_num <= 16'h0000;
          aux     <= aux + 8'd1;
        end else begin
          seg_num <= seg_num + 16'd1;
        end
      end
    end
  end

  assign busy  = (state_q != IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_test_packet_gen.sv
// Directed bench for test_packet_gen: a byte-level monitor rebuilds packets
// from tx_en/tx_data and each scenario checks them against hand-derived values.
module tb_test_packet_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] segment_number_max;
  logic        drop_req;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [7:0]  aux;
  logic [15:0] seg_num;
  logic [31:0] sent_count;
  logic [31:0] dropped_count;
  logic        busy;
  logic [1:0]  state;

  test_packet_gen dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .segment_number_max (segment_number_max),
    .drop_req           (drop_req),
    .tx_en              (tx_en),
    .tx_data            (tx_data),
    .aux                (aux),
    .seg_num            (seg_num),
    .sent_count         (sent_count),
    .dropped_count      (dropped_count),
    .busy               (busy),
    .state              (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // counters and checking task
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // packet monitor: one queue entry per received packet
  logic [7:0]  pkt_aux_q[$];
  logic [15:0] pkt_seg_q[$];
  int          pkt_len_q[$];
  int          pkt_start_q[$];
  bit          pkt_fill_q[$];

  bit          in_pkt = 0;
  int          cur_len;
  int          cur_start;
  bit          cur_fill;
  logic [7:0]  cur_aux;
  logic [15:0] cur_seg;
  bit          idle_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0;
    end else if (tx_en) begin
      if (!in_pkt) begin
        in_pkt    = 1;
        cur_len   = 0;
        cur_start = cyc;
        cur_fill  = 1;
      end
      case (cur_len)
        0:       cur_aux       = tx_data;
        1:       cur_seg[15:8] = tx_data;
        2:       cur_seg[7:0]  = tx_data;
        default: if (tx_data != 8'h12) cur_fill = 0;
      endcase
      cur_len++;
    end else begin
      if (tx_data != 8'h00) idle_bad = 1;
      if (in_pkt) begin
        pkt_aux_q.push_back(cur_aux);
        pkt_seg_q.push_back(cur_seg);
        pkt_len_q.push_back(cur_len);
        pkt_start_q.push_back(cur_start);
        pkt_fill_q.push_back(cur_fill);
        in_pkt = 0;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    drop_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    int k = 0;
    while (pkt_len_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (pkt_len_q.size() < n) check({tag, "_timeout"}, 64'(pkt_len_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) check({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_pkt(input string tag, input int i, input logic [7:0] e_aux,
                           input logic [15:0] e_seg);
    check({tag, "_aux"},  64'(pkt_aux_q[i]),  64'(e_aux));
    check({tag, "_seg"},  64'(pkt_seg_q[i]),  64'(e_seg));
    check({tag, "_len"},  64'(pkt_len_q[i]),  64'd33);
    check({tag, "_fill"}, 64'(pkt_fill_q[i]), 64'd1);
  endtask

  initial begin
    int base;
    int t0;
    int ok_cnt;
    int ng_cnt;
    logic [7:0] exp_aux;

    rst = 1'b1;
    enable = 1'b0;
    drop_req = 1'b0;
    segment_number_max = 16'd3;

    // reset state
    do_reset();
    check("rst_tx_en",   64'(tx_en),         64'd0);
    check("rst_tx_data", 64'(tx_data),       64'd0);
    check("rst_aux",     64'(aux),           64'd0);
    check("rst_seg",     64'(seg_num),       64'd0);
    check("rst_sent",    64'(sent_count),    64'd0);
    check("rst_dropped", 64'(dropped_count), 64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_state",   64'(state),         64'd0);

    // basic rounds, max=3, plus first-byte latency
    base = pkt_len_q.size();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("lat_state", 64'(state), 64'd1);
    check("lat_tx_en0", 64'(tx_en), 64'd0);
    @(negedge clk);
    check("lat_tx_en1", 64'(tx_en), 64'd1);
    check("lat_byte0",  64'(tx_data), 64'd0);
    wait_pkts("basic", base + 4, 400);
    enable = 1'b0;
    wait_idle("basic", 100);
    check_pkt("basic_p0", base + 0, 8'h00, 16'd0);
    check_pkt("basic_p1", base + 1, 8'h00, 16'd1);
    check_pkt("basic_p2", base + 2, 8'h00, 16'd2);
    check_pkt("basic_p3", base + 3, 8'h01, 16'd0);
    for (int i = 1; i < 4; i++)
      check("basic_period", 64'(pkt_start_q[base + i] - pkt_start_q[base + i - 1]), 64'd43);

    // drop slots 2 and 3 of 5, max=50
    do_reset();
    segment_number_max = 16'd50;
    base = pkt_len_q.size();
    enable = 1'b1;
    @(posedge clk);
    repeat (42) @(posedge clk);
    @(negedge clk);
    drop_req = 1'b1;
    repeat (44) @(posedge clk);
    @(negedge clk);
    drop_req = 1'b0;
    wait_pkts("drop", base + 3, 400);
    enable = 1'b0;
    wait_idle("drop", 100);
    check_pkt("drop_p0", base + 0, 8'h00, 16'd0);
    check_pkt("drop_p1", base + 1, 8'h00, 16'd3);
    check_pkt("drop_p2", base + 2, 8'h00, 16'd4);
    check("drop_silence", 64'(pkt_start_q[base + 1] - pkt_start_q[base]), 64'd129);
    check("drop_sent",    64'(sent_count),    64'd3);
    check("drop_dropped", 64'(dropped_count), 64'd2);
    check("drop_seg_end", 64'(seg_num),       64'd5);

    // enable dropped at byte 10: packet and gap complete, then idle
    do_reset();
    segment_number_max = 16'd3;
    base = pkt_len_q.size();
    enable = 1'b1;
    t0 = 0;
    while (!tx_en && t0 < 20) begin
      @(negedge clk);
      t0++;
    end
    check("en_drop_started", 64'(tx_en), 64'd1);
    repeat (10) @(negedge clk);
    check("en_drop_byte10", 64'(tx_data), 64'h12);
    enable = 1'b0;
    t0 = 10;
    while (busy && t0 < 100) begin
      @(negedge clk);
      t0++;
    end
    check("en_drop_busy_fall", 64'(t0), 64'd42);
    check("en_drop_state", 64'(state), 64'd0);
    @(negedge clk);
    check("en_drop_npkts", 64'(pkt_len_q.size() - base), 64'd1);
    check("en_drop_len",   64'(pkt_len_q[base]), 64'd33);
    check("en_drop_sent",  64'(sent_count), 64'd1);

    // max=0 behaves as 1
    do_reset();
    segment_number_max = 16'd0;
    base = pkt_len_q.size();
    enable = 1'b1;
    wait_pkts("max0", base + 3, 300);
    enable = 1'b0;
    wait_idle("max0", 100);
    check_pkt("max0_p0", base + 0, 8'h00, 16'd0);
    check_pkt("max0_p1", base + 1, 8'h01, 16'd0);
    check_pkt("max0_p2", base + 2, 8'h02, 16'd0);

    // reset pulsed at byte 15 of the second packet
    do_reset();
    segment_number_max = 16'd5;
    base = pkt_len_q.size();
    enable = 1'b1;
    wait_pkts("rstmid", base + 1, 200);
    t0 = 0;
    while (!tx_en && t0 < 40) begin
      @(negedge clk);
      t0++;
    end
    repeat (15) @(negedge clk);
    check("rstmid_pre_seg", 64'(seg_num), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_tx_en", 64'(tx_en),         64'd0);
    check("rstmid_sent",  64'(sent_count),    64'd0);
    check("rstmid_aux",   64'(aux),           64'd0);
    check("rstmid_seg",   64'(seg_num),       64'd0);
    check("rstmid_state", 64'(state),         64'd0);
    rst = 1'b0;
    wait_pkts("rstmid", base + 2, 200);
    enable = 1'b0;
    wait_idle("rstmid", 100);
    check_pkt("rstmid_p1", base + 1, 8'h00, 16'd0);

    // 256 rounds with max=1: aux wraps, loopback receiver model
    do_reset();
    segment_number_max = 16'd1;
    base = pkt_len_q.size();
    enable = 1'b1;
    wait_pkts("wrap", base + 256, 256 * 43 + 200);
    enable = 1'b0;
    wait_idle("wrap", 100);
    ok_cnt = 0;
    ng_cnt = 0;
    exp_aux = 8'h00;
    for (int i = 0; i < 256; i++) begin
      if (pkt_aux_q[base + i] == exp_aux && pkt_seg_q[base + i] == 16'd0 &&
          pkt_len_q[base + i] == 33 && pkt_fill_q[base + i])
        ok_cnt++;
      else
        ng_cnt++;
      exp_aux = exp_aux + 8'd1;
    end
    check("wrap_last_aux", 64'(pkt_aux_q[base + 255]), 64'hff);
    check("wrap_ok",       64'(ok_cnt), 64'd256);
    check("wrap_ng",       64'(ng_cnt), 64'd0);
    check("wrap_sent",     64'(sent_count), 64'd256);
    check("wrap_dropped",  64'(dropped_count), 64'd0);
    check("wrap_aux_now",  64'(aux), 64'h00);
    check("idle_data_zero", 64'(idle_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
